aes_masking_entropy_responder: RTL and testbench

EDN-side responder serving the AES masking PRNG entropy interface: answers `entropy_masking_req` with `entropy_masking_ack` plus a data word. Prefetches words from an upstream EDN endpoint into a small FIFO so reseeds at block-counter expiry complete without a full EDN round trip. Sits between the EDN endpoint and the AES core's masking PRNG. Adds flush, FIPS filtering and a sticky starvation timeout.

---
 rtl/aes_masking_entropy_responder.sv | 153 +++++++++++++++
 tb/tb_aes_masking_entropy_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_masking_entropy_responder.sv
// EDN-side entropy responder for the AES masking PRNG.
// Prefetches upstream words into a FIFO and serves req/ack pops.
module aes_masking_entropy_responder #(
    parameter int unsigned EntropyWidth = 32,
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned ReqTimeout   = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            enable_i,
    input  logic                            flush_i,
    input  logic                            fips_required_i,
    output logic                            edn_req_o,
    input  logic                            edn_ack_i,
    input  logic [EntropyWidth-1:0]         edn_bus_i,
    input  logic                            edn_fips_i,
    input  logic                            entropy_masking_req,
    output logic                            entropy_masking_ack,
    output logic [EntropyWidth-1:0]         entropy_o,
    output logic [$clog2(FifoDepth+1)-1:0]  fifo_level_o,
    output logic                            fips_drop_o,
    output logic                            timeout_o
);

    localparam int unsigned LvlW = $clog2(FifoDepth + 1);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(ReqTimeout + 1);

    localparam logic [LvlW-1:0] Full  = LvlW'(FifoDepth);
    localparam logic [CntW-1:0] TMax  = CntW'(ReqTimeout);
    localparam logic [CntW-1:0] TLast = CntW'(ReqTimeout - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [EntropyWidth-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]         level_q;
    logic [CntW-1:0]         cnt_q;
    logic                    req_q;
    logic                    timeout_q;
    logic                    drop_q;

    logic not_empty;
    logic room;
    logic push;
    logic pop;
    logic drop;
    logic start;
    logic busy;

    assign not_empty = (level_q != '0);
    assign room      = (level_q != Full);
    assign busy      = (state_q != IDLE);

    assign pop = entropy_masking_req && enable_i
               && not_empty && !flush_i;

    assign entropy_masking_ack = pop;
    assign entropy_o    = not_empty ? mem_q[rd_ptr_q] : '0;
    assign fifo_level_o = level_q;
    assign edn_req_o    = req_q;
    assign fips_drop_o  = drop_q;
    assign timeout_o    = timeout_q;

    // An outstanding request is never withdrawn; flush only
    // turns the eventual word into a discard.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        drop    = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i && room && !flush_i) begin
                    state_d = REQ;
                    start   = 1'b1;
                end
            end
            REQ: begin
                if (edn_ack_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        if (fips_required_i && !edn_fips_i) begin
                            drop = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (edn_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            drop_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d != IDLE);
            drop_q  <= drop;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                unique case ({push, pop})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
            end
            if (start) begin
                cnt_q <= '0;
            end else if (busy && cnt_q != TMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (busy && cnt_q == TLast) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= edn_bus_i;
        end
    end

endmodule

// File: tb/tb_aes_masking_entropy_responder.sv
// Directed bench for aes_masking_entropy_responder.
// Cycle table plus hand-written timeout and reset sequences.
module tb_aes_masking_entropy_responder;

    localparam int W = 32;
    localparam int D = 4;
    localparam int T = 10;
    localparam int LW = $clog2(D + 1);

    localparam logic [W-1:0] A1 = 32'hA5A5_0001;
    localparam logic [W-1:0] A2 = 32'hA5A5_0002;
    localparam logic [W-1:0] A3 = 32'hA5A5_0003;
    localparam logic [W-1:0] A4 = 32'hA5A5_0004;
    localparam logic [W-1:0] A5 = 32'hA5A5_0005;
    localparam logic [W-1:0] B1 = 32'h1111_0001;
    localparam logic [W-1:0] C1 = 32'hC0C0_0001;
    localparam logic [W-1:0] C2 = 32'hC0C0_0002;
    localparam logic [W-1:0] D1 = 32'hDDDD_0001;
    localparam logic [W-1:0] D2 = 32'hDDDD_0002;
    localparam logic [W-1:0] D3 = 32'hDDDD_0003;
    localparam logic [W-1:0] E1 = 32'hEEEE_0001;
    localparam logic [W-1:0] F1 = 32'hF00D_0001;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, fl, fr;
    logic          edn_req, edn_ack, edn_fips;
    logic [W-1:0]  edn_bus;
    logic          areq, aack;
    logic [W-1:0]  ent;
    logic [LW-1:0] lvl;
    logic          drop, to;

    always #5 clk = ~clk;

    aes_masking_entropy_responder #(
        .EntropyWidth(W),
        .FifoDepth(D),
        .ReqTimeout(T)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(en),
        .flush_i(fl),
        .fips_required_i(fr),
        .edn_req_o(edn_req),
        .edn_ack_i(edn_ack),
        .edn_bus_i(edn_bus),
        .edn_fips_i(edn_fips),
        .entropy_masking_req(areq),
        .entropy_masking_ack(aack),
        .entropy_o(ent),
        .fifo_level_o(lvl),
        .fips_drop_o(drop),
        .timeout_o(to)
    );

    typedef struct {
        logic          en, fl, fr, ack;
        logic [W-1:0]  data;
        logic          fips, areq;
        logic          req, aack;
        logic [W-1:0]  ent;
        logic [LW-1:0] lvl;
        logic          drop, to;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void v(
        input logic en_, fl_, fr_, ack_,
        input logic [W-1:0] data_,
        input logic fips_, areq_, req_, aack_,
        input logic [W-1:0] ent_,
        input int lvl_,
        input logic drop_, to_
    );
        vec_t x;
        x.en = en_;   x.fl = fl_;   x.fr = fr_;
        x.ack = ack_; x.data = data_;
        x.fips = fips_; x.areq = areq_;
        x.req = req_; x.aack = aack_; x.ent = ent_;
        x.lvl = LW'(lvl_); x.drop = drop_; x.to = to_;
        vecs.push_back(x);
    endfunction

    // Packed view: {req, ack, drop, timeout, level, entropy}
    function automatic logic [63:0] pack(
        input logic r, a, d, t,
        input logic [LW-1:0] l,
        input logic [W-1:0] e
    );
        return 64'({r, a, d, t, l, e});
    endfunction

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return pack(edn_req, aack, drop, to, lvl, ent);
    endfunction

    task automatic idle_inputs();
        en = 1'b0; fl = 1'b0; fr = 1'b0;
        edn_ack = 1'b0; edn_bus = '0; edn_fips = 1'b0;
        areq = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // en rf fr ack data fips areq | req aack ent lvl drop to
        v(1,0,0,0,0 ,0,0, 1,0,0 ,0,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,0 ,0,0,0);
        v(1,0,0,1,A1,1,0, 1,0,0 ,0,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,A1,1,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,A1,1,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,A1,1,0,0);
        v(1,0,0,1,A2,1,0, 1,0,A1,1,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,A1,2,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,A1,2,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,A1,2,0,0);
        v(1,0,0,1,A3,1,0, 1,0,A1,2,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,A1,3,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,A1,3,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,A1,3,0,0);
        v(1,0,0,1,A4,1,0, 1,0,A1,3,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,A1,4,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,A1,4,0,0);
        v(1,0,0,0,0 ,0,1, 0,1,A1,4,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,A2,3,0,0);
        v(1,0,0,0,0 ,0,1, 1,1,A2,3,0,0);
        v(1,0,0,1,A5,1,1, 1,1,A3,2,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,A4,2,0,0);
        v(1,0,0,0,0 ,0,1, 1,1,A4,2,0,0);
        v(1,0,0,0,0 ,0,1, 1,1,A5,1,0,0);
        v(1,0,0,0,0 ,0,1, 1,0,0 ,0,0,0);
        v(1,0,0,1,B1,1,1, 1,0,0 ,0,0,0);
        v(1,0,0,0,0 ,0,1, 0,1,B1,1,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,0 ,0,0,0);
        v(1,0,1,1,C1,0,0, 1,0,0 ,0,0,0);
        v(1,0,1,0,0 ,0,0, 0,0,0 ,0,1,0);
        v(1,0,1,1,C2,1,0, 1,0,0 ,0,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,C2,1,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,C2,1,0,0);
        v(1,1,0,0,0 ,0,1, 1,0,C2,1,0,0);
        v(1,0,0,0,0 ,0,0, 1,0,0 ,0,0,0);
        v(1,0,0,1,D1,1,0, 1,0,0 ,0,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,0 ,0,0,0);
        v(1,0,0,1,D2,1,0, 1,0,0 ,0,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,D2,1,0,0);
        v(0,0,0,0,0 ,0,1, 1,0,D2,1,0,0);
        v(0,0,0,1,D3,1,0, 1,0,D2,1,0,0);
        v(0,0,0,0,0 ,0,0, 0,0,D2,2,0,0);
        v(0,0,0,0,0 ,0,0, 0,0,D2,2,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,D2,2,0,0);
        v(1,1,0,1,E1,1,0, 1,0,D2,2,0,0);
        v(1,0,0,0,0 ,0,0, 0,0,0 ,0,0,0);

        repeat (3) @(negedge clk);
        areq = 1'b1;
        #1 check("reset_state", outs(), pack(0,0,0,0,0,0));
        areq = 1'b0;
        rst = 1'b0;
        en  = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            en = vecs[i].en; fl = vecs[i].fl;
            fr = vecs[i].fr; edn_ack = vecs[i].ack;
            edn_bus = vecs[i].data;
            edn_fips = vecs[i].fips;
            areq = vecs[i].areq;
            #1;
            check($sformatf("row%0d", i), outs(),
                  pack(vecs[i].req, vecs[i].aack,
                       vecs[i].drop, vecs[i].to,
                       vecs[i].lvl, vecs[i].ent));
        end

        // Starvation: EDN never answers.
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            #1;
            if (i == T - 1) begin
                check("timeout_before", outs(),
                      pack(1,0,0,0,0,0));
            end
        end
        @(negedge clk);
        #1 check("timeout_rise", outs(), pack(1,0,0,1,0,0));
        repeat (5) @(negedge clk);
        #1 check("timeout_sticky", outs(), pack(1,0,0,1,0,0));

        @(negedge clk);
        edn_ack = 1'b1; edn_bus = F1; edn_fips = 1'b1;
        @(negedge clk);
        edn_ack = 1'b0; edn_bus = '0;
        #1 check("late_ack_push", outs(), pack(0,0,0,1,1,F1));
        @(negedge clk);
        #1 check("rereq_after_late", outs(), pack(1,0,0,1,1,F1));

        // Asynchronous reset in the middle of a request.
        #2 rst = 1'b1;
        #1 check("async_reset", outs(), pack(0,0,0,0,0,0));
        @(negedge clk);
        #1 check("held_reset", outs(), pack(0,0,0,0,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
